// File: rtl/pack4_feeder_pkg.sv
// pack4_feeder_pkg
// Types, constants and helpers shared between the conv-datapath lane
// packer and the 4-input adder trees that consume its vectors.
//   LANES / DATA_W : default lane count and sample width.
//   lane_vec_t     : lane vector at the default configuration; lane 0 is
//                    the first sample of the group.
//   keep_mask()    : bit k set for every lane k below a fill count.
//   zero_pad()     : lane vector with every lane at or above the count
//                    forced to zero.
package pack4_feeder_pkg;

  localparam int LANES     = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_LANES = 32;

  typedef logic [LANES-1:0][DATA_W-1:0] lane_vec_t;

  function automatic logic [MAX_LANES-1:0] keep_mask(input int count);
    logic [MAX_LANES-1:0] m;
    m = '0;
    for (int k = 0; k < MAX_LANES; k++) begin
      if (k < count) m[k] = 1'b1;
    end
    return m;
  endfunction

  function automatic lane_vec_t zero_pad(input lane_vec_t v, input int count);
    lane_vec_t r;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      if (k < count) r[k] = v[k];
    end
    return r;
  endfunction

endpackage

// File: rtl/pack4_feeder_if.sv
// pack4_feeder_if
// Bundles the upstream sample handshake and the downstream lane-vector
// handshake of the packer.
//   upstream   : ivalid, iready, idata, ilast
//   downstream : ovalid, odready, odata, ocount, olast
// Modports:
//   slave  - the packer itself (consumes samples, produces vectors)
//   master - the environment around it (produces samples, consumes vectors)
interface pack4_feeder_if
  import pack4_feeder_pkg::*;
#(
  parameter int pDATA_W = DATA_W,
  parameter int pLANES  = LANES,
  parameter int pCNT_W  = $clog2(pLANES + 1)
);

  logic                             ivalid;
  logic                             iready;
  logic [pDATA_W-1:0]               idata;
  logic                             ilast;
  logic                             ovalid;
  logic                             odready;
  logic [pLANES-1:0][pDATA_W-1:0]   odata;
  logic [pCNT_W-1:0]                ocount;
  logic                             olast;

  modport slave (
    input  ivalid, idata, ilast, odready,
    output iready, ovalid, odata, ocount, olast
  );

  modport master (
    output ivalid, idata, ilast, odready,
    input  iready, ovalid, odata, ocount, olast
  );

endinterface

// File: rtl/pack4_feeder_vec_out_reg.sv
// pack4_feeder_vec_out_reg
// Output register for the packed lane vector with valid/ready hold.
//   iclk, irst : clock, synchronous active-high reset
//   load       : a completed vector is presented this cycle
//   load_vec, load_cnt, load_last : payload of that vector
//   odready    : downstream ready
//   ovalid, odata, ocount, olast  : registered vector and its handshake
// The packer only asserts load while the register is empty or being
// drained this cycle, so a load never overwrites an untransferred vector.
module pack4_feeder_vec_out_reg #(
  parameter int pDATA_W = 8,
  parameter int pLANES  = 4,
  parameter int pCNT_W  = 3
) (
  input  logic                           iclk,
  input  logic                           irst,
  input  logic                           load,
  input  logic [pLANES-1:0][pDATA_W-1:0] load_vec,
  input  logic [pCNT_W-1:0]              load_cnt,
  input  logic                           load_last,
  input  logic                           odready,
  output logic                           ovalid,
  output logic [pLANES-1:0][pDATA_W-1:0] odata,
  output logic [pCNT_W-1:0]              ocount,
  output logic                           olast
);

  logic                           vld_p1;
  logic [pLANES-1:0][pDATA_W-1:0] vec_p1;
  logic [pCNT_W-1:0]              cnt_p1;
  logic                           last_p1;

  // Stage p1: output vector register
  always_ff @(posedge iclk) begin
    if (irst) begin
      vld_p1  <= 1'b0;
      vec_p1  <= '0;
      cnt_p1  <= '0;
      last_p1 <= 1'b0;
    end else if (load) begin
      vld_p1  <= 1'b1;
      vec_p1  <= load_vec;
      cnt_p1  <= load_cnt;
      last_p1 <= load_last;
    end else if (vld_p1 && odready) begin
      // payload keeps its last value; only valid drops
      vld_p1 <= 1'b0;
    end
  end

  assign ovalid = vld_p1;
  assign odata  = vec_p1;
  assign ocount = cnt_p1;
  assign olast  = last_p1;

endmodule

// File: rtl/pack4_feeder.sv
// pack4_feeder
// Serial-to-parallel packer feeding the pipelined 4-input adder trees.
// One sample per accepted beat is written into the next lane of the pack
// register; a beat that fills the last lane or carries ilast completes the
// vector, which is registered and presented downstream one cycle later.
// Lanes that were never filled read as zero so downstream sums are exact.
//   iclk, irst : clock, synchronous active-high reset
//   bus        : pack4_feeder_if.slave
//                upstream   ivalid/iready/idata/ilast
//                downstream ovalid/odready/odata/ocount/olast
module pack4_feeder
  import pack4_feeder_pkg::*;
#(
  parameter int pDATA_W = DATA_W,
  parameter int pLANES  = LANES,
  parameter int pCNT_W  = $clog2(pLANES + 1)
) (
  input  logic           iclk,
  input  logic           irst,
  pack4_feeder_if.slave  bus
);

  logic [pCNT_W-1:0]              cnt_p0;
  logic [pLANES-1:0][pDATA_W-1:0] pack_p0;
  logic [pLANES-1:0][pDATA_W-1:0] vec_nxt;
  logic [pLANES-1:0]              keep;
  logic                           beat;
  logic                           last_lane;
  logic                           done;

  // Ready depends only on the output register state, never on ivalid or
  // ilast, so no combinational path loops back to upstream.
  assign bus.iready = !bus.ovalid || bus.odready;
  assign beat       = bus.ivalid && bus.iready;
  assign last_lane  = (cnt_p0 == pCNT_W'(pLANES - 1));
  assign done       = beat && (last_lane || bus.ilast);

  // Lanes up to and including the one being written stay; the rest are
  // forced to zero so a partial vector never exposes stale samples.
  assign keep = pLANES'(keep_mask(int'(cnt_p0) + 1));

  always_comb begin
    vec_nxt = '0;
    for (int k = 0; k < pLANES; k++) begin
      if (keep[k]) begin
        vec_nxt[k] = (pCNT_W'(k) == cnt_p0) ? bus.idata : pack_p0[k];
      end
    end
  end

  // Stage p0: lane counter and pack register
  always_ff @(posedge iclk) begin
    if (irst) begin
      cnt_p0  <= '0;
      pack_p0 <= '0;
    end else if (beat) begin
      if (done) begin
        cnt_p0  <= '0;
        pack_p0 <= '0;
      end else begin
        cnt_p0  <= cnt_p0 + pCNT_W'(1);
        pack_p0 <= vec_nxt;
      end
    end
  end

  // Stage p1: completed vector handed to the output register
  pack4_feeder_vec_out_reg #(
    .pDATA_W (pDATA_W),
    .pLANES  (pLANES),
    .pCNT_W  (pCNT_W)
  ) u_out (
    .iclk      (iclk),
    .irst      (irst),
    .load      (done),
    .load_vec  (vec_nxt),
    .load_cnt  (cnt_p0 + pCNT_W'(1)),
    .load_last (bus.ilast),
    .odready   (bus.odready),
    .ovalid    (bus.ovalid),
    .odata     (bus.odata),
    .ocount    (bus.ocount),
    .olast     (bus.olast)
  );

endmodule

// File: tb/tb_pack4_feeder.sv
// tb_pack4_feeder
// Directed cycle table for exact latency/stall/reset behaviour, followed
// by a randomized stream scored against a queue-based group model.
module tb_pack4_feeder;
  import pack4_feeder_pkg::*;

  localparam int DW = 8;
  localparam int L  = 4;
  localparam int CW = $clog2(L + 1);

  logic clk;
  logic rst;

  pack4_feeder_if #(.pDATA_W(DW), .pLANES(L), .pCNT_W(CW)) bus ();

  pack4_feeder #(.pDATA_W(DW), .pLANES(L), .pCNT_W(CW)) dut (
    .iclk (clk),
    .irst (rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          rst;
    bit          v;
    logic [7:0]  d;
    bit          l;
    bit          rdy;
    bit          e_irdy;
    bit          e_ov;
    bit          chkd;
    logic [31:0] e_d;
    int          e_cnt;
    bit          e_last;
  } row_t;

  row_t tbl[$];

  task automatic add(input bit r, input bit v, input logic [7:0] d, input bit l,
                     input bit rdy, input bit ei, input bit eo, input bit c,
                     input logic [31:0] ed, input int ec, input bit el);
    row_t x;
    x.rst = r; x.v = v; x.d = d; x.l = l; x.rdy = rdy;
    x.e_irdy = ei; x.e_ov = eo; x.chkd = c; x.e_d = ed; x.e_cnt = ec; x.e_last = el;
    tbl.push_back(x);
  endtask

  // Random-phase reference model: accepted samples grouped by the packing
  // rules; completed groups wait in out_q until transferred.
  typedef struct {
    logic [31:0] vec;
    int          cnt;
    bit          last;
  } grp_t;

  grp_t        out_q[$];
  logic [7:0]  cur[$];
  longint      sum_model = 0;
  longint      sum_dut   = 0;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.ivalid  = 1'b0;
    bus.idata   = '0;
    bus.ilast   = 1'b0;
    bus.odready = 1'b1;

    //   rst v  d     l rdy | irdy ov chk data          cnt last
    add(1, 0, 8'h00, 0, 1,   1,   0, 1, 32'h00000000, 0, 0);
    add(1, 0, 8'h00, 0, 1,   1,   0, 1, 32'h00000000, 0, 0);
    // continuous 1..8
    add(0, 1, 8'd1,  0, 1,   1,   0, 0, 32'h0, 0, 0);
    add(0, 1, 8'd2,  0, 1,   1,   0, 0, 32'h0, 0, 0);
    add(0, 1, 8'd3,  0, 1,   1,   0, 0, 32'h0, 0, 0);
    add(0, 1, 8'd4,  0, 1,   1,   1, 1, 32'h04030201, 4, 0);
    add(0, 1, 8'd5,  0, 1,   1,   0, 0, 32'h0, 0, 0);
    add(0, 1, 8'd6,  0, 1,   1,   0, 0, 32'h0, 0, 0);
    add(0, 1, 8'd7,  0, 1,   1,   0, 0, 32'h0, 0, 0);
    add(0, 1, 8'd8,  0, 1,   1,   1, 1, 32'h08070605, 4, 0);
    // early close on 10, then 11 starts at lane 0
    add(0, 1, 8'd9,  0, 1,   1,   0, 0, 32'h0, 0, 0);
    add(0, 1, 8'd10, 1, 1,   1,   1, 1, 32'h00000A09, 2, 1);
    add(0, 1, 8'd11, 0, 1,   1,   0, 0, 32'h0, 0, 0);
    add(0, 1, 8'd12, 0, 1,   1,   0, 0, 32'h0, 0, 0);
    add(0, 1, 8'd13, 1, 1,   1,   1, 1, 32'h000D0C0B, 3, 1);
    // single-sample group
    add(0, 0, 8'h00, 0, 1,   1,   0, 0, 32'h0, 0, 0);
    add(0, 1, 8'h7F, 1, 1,   1,   1, 1, 32'h0000007F, 1, 1);
    // ilast without ivalid is ignored
    add(0, 0, 8'hEE, 1, 1,   1,   0, 0, 32'h0, 0, 0);
    add(0, 1, 8'd1,  0, 1,   1,   0, 0, 32'h0, 0, 0);
    add(0, 1, 8'd2,  0, 1,   1,   0, 0, 32'h0, 0, 0);
    add(0, 1, 8'd3,  0, 1,   1,   0, 0, 32'h0, 0, 0);
    add(0, 1, 8'd4,  0, 1,   1,   1, 1, 32'h04030201, 4, 0);
    // 5-cycle stall; offered beat carries ilast and must not be taken
    add(0, 1, 8'd5,  1, 0,   0,   1, 1, 32'h04030201, 4, 0);
    add(0, 1, 8'd5,  1, 0,   0,   1, 1, 32'h04030201, 4, 0);
    add(0, 1, 8'd5,  1, 0,   0,   1, 1, 32'h04030201, 4, 0);
    add(0, 1, 8'd5,  1, 0,   0,   1, 1, 32'h04030201, 4, 0);
    add(0, 1, 8'd5,  1, 0,   0,   1, 1, 32'h04030201, 4, 0);
    add(0, 1, 8'd5,  0, 1,   1,   0, 0, 32'h0, 0, 0);
    add(0, 1, 8'd6,  0, 1,   1,   0, 0, 32'h0, 0, 0);
    add(0, 1, 8'd7,  0, 1,   1,   0, 0, 32'h0, 0, 0);
    add(0, 1, 8'd8,  0, 1,   1,   1, 1, 32'h08070605, 4, 0);
    // completing beat and output transfer in the same cycle
    add(0, 1, 8'h21, 1, 1,   1,   1, 1, 32'h00000021, 1, 1);
    add(0, 1, 8'h22, 1, 1,   1,   1, 1, 32'h00000022, 1, 1);
    // reset mid-group
    add(0, 1, 8'h30, 0, 1,   1,   0, 0, 32'h0, 0, 0);
    add(0, 1, 8'h31, 0, 1,   1,   0, 0, 32'h0, 0, 0);
    add(1, 1, 8'h32, 0, 1,   1,   0, 1, 32'h00000000, 0, 0);
    add(0, 1, 8'd20, 0, 1,   1,   0, 0, 32'h0, 0, 0);
    add(0, 1, 8'd21, 0, 1,   1,   0, 0, 32'h0, 0, 0);
    add(0, 1, 8'd22, 0, 1,   1,   0, 0, 32'h0, 0, 0);
    add(0, 1, 8'd23, 0, 1,   1,   1, 1, 32'h17161514, 4, 0);
    add(0, 0, 8'h00, 0, 1,   1,   0, 0, 32'h0, 0, 0);
    // reset while the output is stalled
    add(0, 1, 8'd1,  0, 1,   1,   0, 0, 32'h0, 0, 0);
    add(0, 1, 8'd2,  0, 1,   1,   0, 0, 32'h0, 0, 0);
    add(0, 1, 8'd3,  0, 1,   1,   0, 0, 32'h0, 0, 0);
    add(0, 1, 8'd4,  0, 1,   1,   1, 1, 32'h04030201, 4, 0);
    add(1, 1, 8'h55, 0, 0,   0,   0, 1, 32'h00000000, 0, 0);
    add(0, 0, 8'h00, 0, 0,   1,   0, 0, 32'h0, 0, 0);
    add(0, 1, 8'h40, 1, 0,   1,   1, 1, 32'h00000040, 1, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst         = tbl[i].rst;
      bus.ivalid  = tbl[i].v;
      bus.idata   = tbl[i].d;
      bus.ilast   = tbl[i].l;
      bus.odready = tbl[i].rdy;
      #1;
      chk($sformatf("row%0d_iready", i), 64'(bus.iready), 64'(tbl[i].e_irdy));
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_ovalid", i), 64'(bus.ovalid), 64'(tbl[i].e_ov));
      if (tbl[i].chkd) begin
        chk($sformatf("row%0d_odata", i), 64'(bus.odata), 64'(tbl[i].e_d));
        chk($sformatf("row%0d_ocount", i), 64'(bus.ocount), 64'(tbl[i].e_cnt));
        chk($sformatf("row%0d_olast", i), 64'(bus.olast), 64'(tbl[i].e_last));
      end
    end

    // Randomized phase
    @(negedge clk);
    rst = 1'b1;
    bus.ivalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    begin
      int  n_acc;
      int  drain;
      int  cyc;
      bit  e_ov;
      bit  e_rdy;
      bit  xfer;
      bit  beat;
      n_acc = 0;
      drain = 0;
      cyc   = 0;
      while (drain < 12 && cyc < 20000) begin
        cyc++;
        @(negedge clk);
        if (n_acc < 1000) begin
          bus.ivalid  = 1'($urandom_range(0, 1));
          bus.idata   = 8'($urandom);
          bus.ilast   = ($urandom_range(0, 4) == 0) || (n_acc == 999);
          bus.odready = 1'($urandom_range(0, 1));
        end else begin
          bus.ivalid  = 1'b0;
          bus.ilast   = 1'b0;
          bus.odready = 1'b1;
          drain++;
        end
        #1;
        e_ov  = (out_q.size() != 0);
        e_rdy = !e_ov || bus.odready;
        chk("rnd_iready", 64'(bus.iready), 64'(e_rdy));
        chk("rnd_ovalid", 64'(bus.ovalid), 64'(e_ov));
        if (e_ov) begin
          chk("rnd_vector", {27'd0, bus.olast, CW'(bus.ocount), 32'(bus.odata)},
              {27'd0, out_q[0].last, CW'(out_q[0].cnt), out_q[0].vec});
        end
        xfer = e_ov && bus.odready;
        beat = bus.ivalid && e_rdy;
        if (xfer) begin
          for (int k = 0; k < L; k++) sum_dut += longint'(bus.odata[k]);
        end
        @(posedge clk);
        if (xfer) void'(out_q.pop_front());
        if (beat) begin
          n_acc++;
          sum_model += longint'(bus.idata);
          cur.push_back(bus.idata);
          if (bus.ilast || cur.size() == L) begin
            grp_t g;
            g.vec = '0;
            for (int k = 0; k < cur.size(); k++) g.vec[k*8 +: 8] = cur[k];
            g.cnt  = cur.size();
            g.last = bus.ilast;
            out_q.push_back(g);
            cur.delete();
          end
        end
      end
      chk("rnd_samples_accepted", 64'(n_acc), 64'd1000);
      chk("rnd_all_drained", 64'(out_q.size() + cur.size()), 64'd0);
      chk("rnd_lane_sum", 64'(sum_dut), 64'(sum_model));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pack4_feeder.md
Name: pack4_feeder

Overview:
- Serial-to-parallel packer that feeds the pipelined 4-input adder trees in the conv datapath.
- Accepts one pDATA_W sample per beat over a valid/ready handshake and assembles pLANES samples into one lane vector; lane 0 is the first sample received.
- Emits the vector with its own valid/ready handshake.
- ilast forces early emission of a partial vector; unfilled lanes are zero, so downstream sums are unaffected.

Parameters:
- pDATA_W, 8, sample width in bits.
- pLANES, 4, lanes per output vector; must be >= 2.
- pCNT_W, $clog2(pLANES+1), width of the lane counter and ocount.

Ports:
- iclk  in  1  clock; all logic on the rising edge.
- irst  in  1  synchronous, active-high reset.
- ivalid  in  1  upstream sample valid.
- iready  out  1  upstream ready; a beat transfers when ivalid && iready.
- idata  in  pDATA_W  upstream sample.
- ilast  in  1  final sample of a group; qualified by the beat.
- ovalid  out  1  output vector valid.
- odready  in  1  downstream ready; a vector transfers when ovalid && odready.
- odata  out  [pLANES][pDATA_W]  packed vector; lane k is the k-th sample received.
- ocount  out  pCNT_W  number of filled lanes, 1..pLANES.
- olast  out  1  vector closes a group, i.e. it contained the ilast beat.

Behaviour:
- Reset (irst=1 at a clock edge): ovalid=0, odata=0, olast=0, ocount=0, internal lane counter cnt=0, pack register cleared. Reset during a partial group or a stalled output discards all data. No output transfer is reported in the reset cycle.
- iready is combinational: iready = !ovalid || odready. It has no dependence on ivalid or ilast, so there is no combinational loop with upstream.
- Accepted beat: idata is written to pack[cnt].
  - The beat completes the vector if cnt == pLANES-1 or ilast=1.
  - Non-completing beat: cnt <= cnt+1.
- Completing beat, next edge:
  - odata <= pack contents including the current sample; lanes above the current one are forced to 0.
  - ocount <= cnt+1; olast <= ilast; ovalid <= 1.
  - cnt <= 0; pack is cleared.
- Latency: the vector appears one cycle after its completing beat.
- Throughput: one sample per cycle while odready=1. A back-to-back completing beat and output transfer in the same cycle loads the new vector with no bubble.
- Output stage:
  - Transfer with no new completing beat: ovalid <= 0. odata, ocount and olast keep their last values; they are only meaningful while ovalid=1.
  - Stall (ovalid=1, odready=0): odata, ocount and olast are held stable, and iready=0.
- ilast when cnt == pLANES-1: a normal full vector with olast=1 and ocount=pLANES.
- ilast as the first sample of a group: ocount=1, lanes 1..pLANES-1 are 0.
- ilast with ivalid=0, or on a beat not accepted (iready=0): ignored.
- idata and ilast are don't-care while ivalid=0.

Decomposition:
- Shared package conv_pkg:
  - typedef of the lane vector, logic [pLANES-1:0][pDATA_W-1:0].
  - localparam LANES=4, shared with the adder tree.
  - a function returning the zero-padded vector for a given count.
- Output register with valid/ready hold is a natural sub-module, vec_out_reg (data, count and last payload; valid/ready in and out).
- The counter, pack register and completion logic stay in the top.

Test Plan:
- Continuous stream 1,2,3,4,5,6,7,8, odready=1, no ilast -> vector {1,2,3,4} ocount=4, then {5,6,7,8}; each valid the cycle after its 4th beat; iready held 1 throughout.
- Samples 9,10 with ilast on 10 -> odata {9,10,0,0}, ocount=2, olast=1; the next sample 11 lands in lane 0.
- Single sample 0x7F with ilast -> {0x7F,0,0,0}, ocount=1, olast=1.
- Hold odready=0 for 5 cycles after vector {1,2,3,4} -> ovalid and odata stable, iready=0, no beats lost. Release -> the next 4 samples pack correctly with no duplication.
- Assert irst after 2 of 4 samples -> outputs 0 the next cycle. A following 4-sample group 20,21,22,23 packs as {20,21,22,23} with no stale lanes.
- Random ivalid/odready (50%), 1000 samples, random ilast -> the scoreboard sum of lanes per vector matches the reference model sum. Results are then fed into the adder tree and checked end to end.
